// File: rtl/cpu_bus_master.sv
// 68030-protocol bus initiator: runs one operand request as 1-4 asynchronous bus
// cycles with dynamic bus sizing, DSACK/BERR synchronizers and a per-cycle timeout.
//   state | meaning
//   IDLE  | waiting for START
//   ADRP  | address/SIZ/RnW driven, strobes still negated
//   ASRT  | nAS low (and nDS for reads)
//   WAIT  | waiting for synchronized DSACK/BERR or timeout
//   RECOV | strobes negated, waiting for DSACK/BERR release
module cpu_bus_master #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [31:0] REQ_ADDR,
  input  logic        REQ_RnW,
  input  logic [1:0]  REQ_SIZ,
  input  logic [31:0] REQ_WDATA,
  output logic [31:0] RDATA,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic        nAS,
  output logic        nDS,
  output logic        RnW,
  output logic [1:0]  SIZ,
  output logic [31:0] ADDR,
  output logic [31:0] DOUT,
  output logic        DOUT_OE,
  input  logic [31:0] DIN,
  input  logic [1:0]  DSACK,
  input  logic        BERR
);

  typedef enum logic [2:0] {S_IDLE, S_ADRP, S_ASRT, S_WAIT, S_RECOV} state_t;

  localparam logic [11:0] TLOAD = 12'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_nxt;
  logic [1:0]  dsack_m, dsack_s;
  logic        berr_m, berr_s;
  logic [2:0]  rem_q, rem_nxt;
  logic [31:0] op_q, op_nxt;
  logic [31:0] acc_q, acc_nxt;
  logic        err_q, err_nxt;
  logic [11:0] tmr_q, tmr_nxt;

  logic [31:0] rdata_nxt, addr_nxt, dout_nxt;
  logic        busy_nxt, done_nxt, erro_nxt, nas_nxt, nds_nxt, rnw_nxt, oe_nxt;
  logic [1:0]  siz_nxt;

  logic [2:0]  req_rem, port_b, avail, n_b, rem_left;
  logic [1:0]  off;
  logic [31:0] req_op, op_shift, acc_tmp, addr_inc;

  // OP0 always sits in bits 31:24; lanes follow the 68030 write multiplexer
  function automatic logic [31:0] wlanes(input logic [1:0] a, input logic [31:0] op);
    logic [7:0] o0, o1, o2, o3, b1, b0;
    {o0, o1, o2, o3} = op;
    case (a)
      2'd0:    b1 = o2;
      2'd1:    b1 = o1;
      default: b1 = o0;
    endcase
    case (a)
      2'd0:    b0 = o3;
      2'd1:    b0 = o2;
      2'd2:    b0 = o1;
      default: b0 = o0;
    endcase
    return {o0, (a[0] ? o0 : o1), b1, b0};
  endfunction

  function automatic logic [7:0] lane_byte(input logic [31:0] d, input logic [1:0] l);
    case (l)
      2'd0:    return d[31:24];
      2'd1:    return d[23:16];
      2'd2:    return d[15:8];
      default: return d[7:0];
    endcase
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      dsack_m <= 2'b00;
      dsack_s <= 2'b00;
      berr_m  <= 1'b0;
      berr_s  <= 1'b0;
      rem_q   <= '0;
      op_q    <= '0;
      acc_q   <= '0;
      err_q   <= 1'b0;
      tmr_q   <= '0;
      RDATA   <= '0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      ERR     <= 1'b0;
      nAS     <= 1'b1;
      nDS     <= 1'b1;
      RnW     <= 1'b1;
      SIZ     <= 2'b00;
      ADDR    <= '0;
      DOUT    <= '0;
      DOUT_OE <= 1'b0;
    end else begin
      state_q <= state_nxt;
      dsack_m <= DSACK;
      dsack_s <= dsack_m;
      berr_m  <= BERR;
      berr_s  <= berr_m;
      rem_q   <= rem_nxt;
      op_q    <= op_nxt;
      acc_q   <= acc_nxt;
      err_q   <= err_nxt;
      tmr_q   <= tmr_nxt;
      RDATA   <= rdata_nxt;
      BUSY    <= busy_nxt;
      DONE    <= done_nxt;
      ERR     <= erro_nxt;
      nAS     <= nas_nxt;
      nDS     <= nds_nxt;
      RnW     <= rnw_nxt;
      SIZ     <= siz_nxt;
      ADDR    <= addr_nxt;
      DOUT    <= dout_nxt;
      DOUT_OE <= oe_nxt;
    end
  end

  // per-cycle transfer size from the acknowledged port width
  always_comb begin
    req_rem = (REQ_SIZ == 2'b00) ? 3'd4 : {1'b0, REQ_SIZ};
    req_op  = REQ_WDATA << {3'd4 - req_rem, 3'b000};
    case (dsack_s)
      2'b11: begin port_b = 3'd4; off = ADDR[1:0];       end
      2'b10: begin port_b = 3'd2; off = {1'b0, ADDR[0]}; end
      default: begin port_b = 3'd1; off = 2'd0;          end
    endcase
    avail    = port_b - {1'b0, off};
    n_b      = (rem_q < avail) ? rem_q : avail;
    rem_left = rem_q - n_b;
    addr_inc = ADDR + {29'd0, n_b};
    op_shift = op_q << {n_b, 3'b000};
    acc_tmp  = acc_q;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < n_b) acc_tmp = {acc_tmp[23:0], lane_byte(DIN, off + 2'(i))};
    end
  end

  always_comb begin
    state_nxt = state_q;
    rem_nxt   = rem_q;
    op_nxt    = op_q;
    acc_nxt   = acc_q;
    err_nxt   = err_q;
    tmr_nxt   = tmr_q;
    rdata_nxt = RDATA;
    busy_nxt  = BUSY;
    done_nxt  = 1'b0;
    erro_nxt  = 1'b0;
    nas_nxt   = nAS;
    nds_nxt   = nDS;
    rnw_nxt   = RnW;
    siz_nxt   = SIZ;
    addr_nxt  = ADDR;
    dout_nxt  = DOUT;
    oe_nxt    = DOUT_OE;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          rem_nxt   = req_rem;
          op_nxt    = req_op;
          acc_nxt   = '0;
          err_nxt   = 1'b0;
          addr_nxt  = REQ_ADDR;
          siz_nxt   = req_rem[1:0];
          rnw_nxt   = REQ_RnW;
          dout_nxt  = wlanes(REQ_ADDR[1:0], req_op);
          oe_nxt    = ~REQ_RnW;
          busy_nxt  = 1'b1;
          state_nxt = S_ADRP;
        end
      end
      S_ADRP: begin
        nas_nxt   = 1'b0;
        nds_nxt   = ~RnW;
        state_nxt = S_ASRT;
      end
      S_ASRT: begin
        nds_nxt   = 1'b0;
        tmr_nxt   = TLOAD;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (berr_s || (dsack_s == 2'b00 && tmr_q == '0)) begin
          nas_nxt   = 1'b1;
          nds_nxt   = 1'b1;
          oe_nxt    = 1'b0;
          err_nxt   = 1'b1;
          rem_nxt   = '0;
          state_nxt = S_RECOV;
        end else if (dsack_s != 2'b00) begin
          nas_nxt   = 1'b1;
          nds_nxt   = 1'b1;
          oe_nxt    = 1'b0;
          rem_nxt   = rem_left;
          addr_nxt  = addr_inc;
          siz_nxt   = rem_left[1:0];
          op_nxt    = op_shift;
          dout_nxt  = wlanes(addr_inc[1:0], op_shift);
          if (RnW) acc_nxt = acc_tmp;
          state_nxt = S_RECOV;
        end else begin
          tmr_nxt = tmr_q - 12'd1;
        end
      end
      S_RECOV: begin
        if (dsack_s == 2'b00 && !berr_s) begin
          if (rem_q != '0) begin
            nas_nxt   = 1'b0;
            nds_nxt   = ~RnW;
            oe_nxt    = ~RnW;
            state_nxt = S_ASRT;
          end else begin
            done_nxt  = 1'b1;
            erro_nxt  = err_q;
            busy_nxt  = 1'b0;
            if (RnW) rdata_nxt = acc_q;
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule
